mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one pipelined WIDTH x WIDTH -> WIDTH multiplier (low-order product bits) among NUM_REQ requesters, e.g. p-bit weight/state update units.
- Round-robin arbitration on the issue side; per-requester valid/ready on both request and response.
- At most one operation in flight per requester; results are held per requester until consumed.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 16, operand and result width; result = (a*b) mod 2^WIDTH
- MUL_LAT, 2, multiplier pipeline stages from issue to result register (>=1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has an operand pair
- req_ready  out  NUM_REQ  one-hot (or zero) grant; handshake when valid&ready
- req_a  in  NUM_REQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand b, same packing
- rsp_valid  out  NUM_REQ  result for requester i held
- rsp_ready  in  NUM_REQ  requester i accepts its result
- rsp_data  out  NUM_REQ*WIDTH  result for requester i, same packing
- busy  out  NUM_REQ  requester i has an op in flight or an unconsumed result

Behaviour:
- Reset: req_ready=0, rsp_valid=0, rsp_data=0, busy=0, all pipeline valid bits 0, rr pointer=0. Reset mid-operation discards in-flight ops and held results; no rsp_valid after reset.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i].
- Grant: combinational round-robin over eligible, search starting at rr pointer, wrapping NUM_REQ-1 -> 0. req_ready = one-hot of the winner, 0 if none eligible. req_ready depends on req_valid; a requester must not make req_valid depend on req_ready.
- On issue of requester g: busy[g]<=1; rr<=(g+1) mod NUM_REQ; {a,b,tag=g,valid} enter pipeline stage 1. rr does not change when there is no issue.
- Throughput: one issue per cycle across all requesters. Pipeline never stalls: each result has a reserved slot because busy blocks reissue.
- Latency: issue handshake at edge t -> rsp_valid[g]=1 and rsp_data[g] valid after edge t+MUL_LAT.
- Arithmetic: unsigned; full 2*WIDTH product truncated to the low WIDTH bits. Two's-complement low bits are therefore also correct.
- Response: rsp_valid[i] and rsp_data[i] hold stable until rsp_valid[i]&rsp_ready[i]. On that edge rsp_valid[i]<=0 and busy[i]<=0. rsp_data[i] keeps its last value.
- Same-cycle events:
  - Consuming a result and issuing for the same requester in one cycle is impossible, because busy is still 1. Earliest reissue is the cycle after consumption.
  - A result landing and a different requester consuming in the same cycle are independent.
- Fairness: a continuously eligible requester is granted within NUM_REQ issue cycles.
- rsp_ready asserted while rsp_valid=0 is ignored.

Decomposition:
- Shared package: constant for clog2(NUM_REQ) tag width; operand/product width localparams derived from WIDTH.
- Sub-module mult_pipe (WIDTH, MUL_LAT, TAGW): registered a*b low bits with a tag and valid shifted alongside, no enable.
- Arbiter, busy bits and result registers live in the top.

Test Plan:
- Single op: NUM_REQ=4, req 2 sends a=0x0003, b=0x0005 at edge t, rsp_ready=1 -> rsp_valid[2] after edge t+2, rsp_data[2]=0x000F, busy[2] clears on consume.
- Truncation: a=0xFFFF, b=0xFFFF -> 0x0001; a=0x1234, b=0x0100 -> 0x3400.
- Contention: all four requesters valid from cycle 0 with rsp_ready=1 -> grants 0,1,2,3 on consecutive cycles, results on cycles 2,3,4,5; the next grant to requester 0 comes only after it consumes.
- Backpressure: requester 1 holds rsp_ready=0 for 10 cycles -> rsp_data[1] stable, req_ready[1] stays 0 despite req_valid[1]; others continue issuing round-robin.
- Reset mid-flight: assert rst one cycle after issue -> after reset rsp_valid=0 and busy=0 forever until new issue; no stale result appears.
- Rotation: only requesters 1 and 3 valid, with rr=2 -> grant 3 first, then 1.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared sizing helpers for the shared-multiplier arbiter and its pipeline.
package mult_share_arbiter_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int WIDTH_DEF   = 16;
  localparam int MUL_LAT_DEF = 2;

  // A single requester still needs a 1-bit tag field.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int TAGW_DEF   = tag_width(NUM_REQ_DEF);
  localparam int PROD_W_DEF = prod_width(WIDTH_DEF);

endpackage

// File: rtl/mult_share_arbiter_mult_pipe.sv
// Free-running multiplier pipeline: low product bits, with tag and valid alongside.
module mult_pipe
  import mult_share_arbiter_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int TAGW    = TAGW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  output logic [TAGW-1:0]  out_tag,
  output logic [WIDTH-1:0] out_p
);

  logic [MUL_LAT:1]            vld_pipe;
  logic [MUL_LAT:1][TAGW-1:0]  tag_pipe;
  logic [MUL_LAT:1][WIDTH-1:0] p_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= in_valid;
      for (int s = 2; s <= MUL_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  // Low WIDTH bits of the product depend only on the low operand bits,
  // so a WIDTH-wide multiply already gives (a*b) mod 2^WIDTH.
  always_ff @(posedge clk) begin
    p_pipe[1]   <= in_a * in_b;
    tag_pipe[1] <= in_tag;
    for (int s = 2; s <= MUL_LAT; s++) begin
      p_pipe[s]   <= p_pipe[s-1];
      tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign out_valid = vld_pipe[MUL_LAT];
  assign out_tag   = tag_pipe[MUL_LAT];
  assign out_p     = p_pipe[MUL_LAT];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NUM_REQ requesters,
// with per-requester busy tracking and held results.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [NUM_REQ*WIDTH-1:0] rsp_data,
  output logic [NUM_REQ-1:0]       busy
);

  localparam int TAGW = tag_width(NUM_REQ);

  logic [NUM_REQ-1:0][WIDTH-1:0] a_v, b_v, data_q;
  logic [NUM_REQ-1:0]            eligible, grant;
  logic [TAGW-1:0]               rr, win, cand;
  logic [TAGW:0]                 sum;
  logic                          issue;
  logic                          p_valid;
  logic [TAGW-1:0]               p_tag;
  logic [WIDTH-1:0]              p_data;

  assign a_v      = req_a;
  assign b_v      = req_b;
  assign eligible = req_valid & ~busy;

  // First eligible requester at or after rr, wrapping modulo NUM_REQ.
  always_comb begin
    grant = '0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr} + (TAGW+1)'(k);
      if (sum >= (TAGW+1)'(NUM_REQ)) sum = sum - (TAGW+1)'(NUM_REQ);
      cand = sum[TAGW-1:0];
      if (grant == '0 && eligible[cand]) begin
        grant[cand] = 1'b1;
        win         = cand;
      end
    end
    if (rst) grant = '0;
  end

  assign issue     = |grant;
  assign req_ready = grant;

  mult_pipe #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT), .TAGW(TAGW)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .in_valid (issue),
    .in_a     (a_v[win]),
    .in_b     (b_v[win]),
    .in_tag   (win),
    .out_valid(p_valid),
    .out_tag  (p_tag),
    .out_p    (p_data)
  );

  // busy blocks reissue, so a landing result never collides with a consume
  // or an issue on the same requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= '0;
      rsp_valid <= '0;
      data_q    <= '0;
      rr        <= '0;
    end else begin
      if (issue) begin
        busy[win] <= 1'b1;
        rr        <= (win == TAGW'(NUM_REQ-1)) ? '0 : win + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
          busy[i]      <= 1'b0;
        end
      end
      if (p_valid) begin
        rsp_valid[p_tag] <= 1'b1;
        data_q[p_tag]    <= p_data;
      end
    end
  end

  assign rsp_data = data_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomized and directed bench for mult_share_arbiter against a transaction-level model.
module tb_mult_share_arbiter;

  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready, busy;
  logic [N*W-1:0] req_a, req_b, rsp_data;

  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LAT(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           tag;
    int           cnt;
    logic [W-1:0] p;
  } op_t;

  bit           m_busy[N];
  bit           m_vld[N];
  logic [W-1:0] m_data[N];
  int           m_rr;
  op_t          fly[$];
  logic [W-1:0] opa[N], opb[N];
  int           checks, failures, last_grant;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0;
      m_vld[i]  = 0;
      m_data[i] = '0;
    end
    m_rr = 0;
    fly.delete();
  endtask

  // One clock: drive, check all outputs against the model, then advance the model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rdy, input bit r);
    logic [N-1:0]     exp_rdy, exp_vld, exp_busy;
    logic [N*W-1:0]   exp_data;
    longint unsigned  prod;
    op_t              o;
    int               g, idx;
    @(negedge clk);
    rst       = r;
    req_valid = v;
    rsp_ready = rdy;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
    #1;
    g = -1;
    if (!r) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && v[idx] && !m_busy[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_vld[i]          = m_vld[i];
      exp_busy[i]         = m_busy[i];
      exp_data[i*W +: W]  = m_data[i];
    end
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_vld));
    chk("busy",      64'(busy),      64'(exp_busy));
    chk("rsp_data",  64'(rsp_data),  64'(exp_data));
    last_grant = g;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      for (int i = 0; i < N; i++)
        if (m_vld[i] && rdy[i]) begin
          m_vld[i]  = 0;
          m_busy[i] = 0;
        end
      for (int j = 0; j < fly.size(); j++) fly[j].cnt--;
      while (fly.size() > 0 && fly[0].cnt == 0) begin
        o = fly.pop_front();
        m_vld[o.tag]  = 1;
        m_data[o.tag] = o.p;
      end
      if (g >= 0) begin
        prod      = longint'(opa[g]) * longint'(opb[g]);
        o.tag     = g;
        o.cnt     = L;
        o.p       = W'(prod % (64'd1 << W));
        m_busy[g] = 1;
        m_rr      = (g + 1) % N;
        fly.push_back(o);
      end
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      opa[i] = W'($urandom);
      opb[i] = W'($urandom);
    end
  endtask

  initial begin
    clk = 0; rst = 1;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    checks = 0; failures = 0; last_grant = -1;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    model_reset();

    step('0, '0, 1);
    step('0, '0, 1);
    step('0, '0, 0);

    // single op, latency and consume
    opa[2] = 16'h0003; opb[2] = 16'h0005;
    step(4'b0100, 4'hF, 0);
    step('0, 4'hF, 0);
    step('0, 4'hF, 0);
    #1;
    chk("single_vld",  64'(rsp_valid[2]), 64'd1);
    chk("single_data", 64'(rsp_data[2*W +: W]), 64'h000F);
    step('0, 4'hF, 0);
    #1;
    chk("single_busy_clr", 64'(busy[2]), 64'd0);

    // truncation
    opa[0] = 16'hFFFF; opb[0] = 16'hFFFF;
    opa[1] = 16'h1234; opb[1] = 16'h0100;
    step(4'b0011, '0, 0);
    step(4'b0011, '0, 0);
    step('0, '0, 0);
    step('0, '0, 0);
    #1;
    chk("trunc_ffff", 64'(rsp_data[0 +: W]), 64'h0001);
    chk("trunc_1234", 64'(rsp_data[W +: W]), 64'h3400);
    step('0, 4'b0011, 0);

    // contention from reset
    step('0, '0, 1);
    rand_ops();
    for (int c = 0; c < 8; c++) begin
      step(4'hF, 4'hF, 0);
      if (c < 4) chk("contend_grant", 64'(last_grant), 64'(c));
    end

    // backpressure on requester 1
    for (int c = 0; c < 12; c++) begin
      rand_ops();
      step(4'hF, 4'b1101, 0);
    end
    for (int c = 0; c < 4; c++) step('0, 4'hF, 0);

    // reset one cycle after issue
    opa[2] = 16'h0007; opb[2] = 16'h0009;
    step(4'b0100, '0, 0);
    step('0, '0, 1);
    for (int c = 0; c < 5; c++) step('0, '0, 0);
    #1;
    chk("rst_vld",  64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // rotation: rr=2 after granting requester 1
    step(4'b0010, 4'hF, 0);
    for (int c = 0; c < 4; c++) step('0, 4'hF, 0);
    step(4'b1010, 4'hF, 0);
    chk("rot_first", 64'(last_grant), 64'd3);
    step(4'b1010, 4'hF, 0);
    chk("rot_second", 64'(last_grant), 64'd1);

    // random traffic with occasional reset
    for (int c = 0; c < 600; c++) begin
      rand_ops();
      step(N'($urandom), N'($urandom) | N'($urandom), ($urandom_range(0, 79) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
